// File: rtl/riscv_v_bw_reduct_unit.sv
// Vector bitwise AND/OR/XOR unit: element-wise beats pass straight through; reduction
// groups fold every srca element plus srcb element 0 into one element of the chosen width.
module riscv_v_bw_lane (
  input  logic [1:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       a_vld,
  output logic [7:0] ew,
  output logic [7:0] a_id
);
  always_comb begin
    a_id = a_vld ? a : ((op == 2'b00) ? 8'hFF : 8'h00);
    case (op)
      2'b00:   ew = a & b;
      2'b01:   ew = a | b;
      2'b10:   ew = a ^ b;
      default: ew = 8'h00;
    endcase
  end
endmodule

module riscv_v_bw_reduct_unit #(
  parameter int NUM_BYTES = 16,
  parameter int MAX_BEATS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic                   in_reduct,
  input  logic [1:0]             in_osize,
  input  logic                   in_last,
  input  logic [NUM_BYTES*8-1:0] srca_data,
  input  logic [NUM_BYTES*8-1:0] srcb_data,
  input  logic [NUM_BYTES-1:0]   srca_bvalid,
  input  logic [NUM_BYTES-1:0]   srcb_bvalid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_BYTES*8-1:0] out_data,
  output logic [NUM_BYTES-1:0]   out_bvalid,
  output logic                   out_err
);
  localparam int W   = NUM_BYTES*8;
  localparam int NCH = NUM_BYTES/8;
  localparam int CW  = $clog2(MAX_BEATS+1);

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nx;

  logic [1:0]           cap_op, cap_osize, eff_op, eff_osize;
  logic [63:0]          acc, acc_nx, ident64, b0, f64, t32, t16, t8, fold, sz_mask;
  logic [CW-1:0]        beat_cnt, beat_num;
  logic                 first, accept, is_red, ovf, done;
  logic [7:0]           bmask;
  logic [W-1:0]         ew, a_id, red_data;
  logic [NUM_BYTES-1:0] red_bv;
  logic                 unused_bv;

  function automatic logic [63:0] comb64(input logic [1:0] op, input logic [63:0] x,
                                         input logic [63:0] y);
    case (op)
      2'b00:   comb64 = x & y;
      2'b01:   comb64 = x | y;
      2'b10:   comb64 = x ^ y;
      default: comb64 = '0;
    endcase
  endfunction

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign first     = (state == IDLE);
  // op/osize come from the wire only on a group's first beat, afterwards from the capture
  assign eff_op    = first ? in_op : cap_op;
  assign eff_osize = first ? in_osize : cap_osize;
  assign is_red    = !first || in_reduct;
  // srcb only contributes element 0 of a reduction; upper byte-valids have no meaning here
  assign unused_bv = ^srcb_bvalid;

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    riscv_v_bw_lane u_lane (
      .op   (eff_op),
      .a    (srca_data[8*i +: 8]),
      .b    (srcb_data[8*i +: 8]),
      .a_vld(srca_bvalid[i]),
      .ew   (ew[8*i +: 8]),
      .a_id (a_id[8*i +: 8])
    );
  end

  // Fold all 64-bit chunks first, then halve down to the element width.
  always_comb begin
    ident64 = (eff_op == 2'b00) ? '1 : '0;
    b0      = '0;
    for (int k = 0; k < 8; k++)
      b0[8*k +: 8] = srcb_bvalid[k] ? srcb_data[8*k +: 8] : ident64[7:0];
    f64 = ident64;
    for (int c = 0; c < NCH; c++) f64 = comb64(eff_op, f64, a_id[64*c +: 64]);
    t32 = comb64(eff_op, f64, f64 >> 32);
    t16 = comb64(eff_op, t32, t32 >> 16);
    t8  = comb64(eff_op, t16, t16 >> 8);
    case (eff_osize)
      2'd0:    begin fold = t8;  bmask = 8'h01; end
      2'd1:    begin fold = t16; bmask = 8'h03; end
      2'd2:    begin fold = t32; bmask = 8'h0F; end
      default: begin fold = f64; bmask = 8'hFF; end
    endcase
    sz_mask = '0;
    for (int k = 0; k < 8; k++) sz_mask[8*k +: 8] = {8{bmask[k]}};
    acc_nx   = comb64(eff_op, first ? b0 : acc, fold) & sz_mask;
    beat_num = first ? CW'(1) : beat_cnt + CW'(1);
    ovf      = (beat_num == CW'(MAX_BEATS)) && !in_last;
    done     = in_last || ovf;
    red_data = '0;
    red_data[63:0] = (eff_op == 2'b11) ? 64'd0 : acc_nx;
    red_bv   = '0;
    red_bv[7:0] = bmask;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && in_reduct && !done) state_nx = ACCUM;
      ACCUM:   if (accept && done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_op     <= '0;
      cap_osize  <= '0;
      acc        <= '0;
      beat_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_bvalid <= '0;
      out_err    <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (!is_red) begin
          out_valid  <= 1'b1;
          out_data   <= ew;
          out_bvalid <= srca_bvalid;
          out_err    <= (eff_op == 2'b11);
        end else begin
          acc      <= acc_nx;
          beat_cnt <= done ? '0 : beat_num;
          if (first) begin
            cap_op    <= in_op;
            cap_osize <= in_osize;
          end
          if (done) begin
            out_valid  <= 1'b1;
            out_data   <= red_data;
            out_bvalid <= red_bv;
            out_err    <= (eff_op == 2'b11) || ovf;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_riscv_v_bw_reduct_unit.sv
// Bench for riscv_v_bw_reduct_unit: directed vector table, multi-cycle corner sequences,
// then random groups checked against an element-level reference model.
module tb_riscv_v_bw_reduct_unit;
  localparam int NB = 16;
  localparam int MB = 8;
  localparam int W  = NB*8;

  logic          clk, rst;
  logic          in_valid, in_ready, in_reduct, in_last, out_valid, out_ready, out_err;
  logic [1:0]    in_op, in_osize;
  logic [W-1:0]  srca_data, srcb_data, out_data;
  logic [NB-1:0] srca_bvalid, srcb_bvalid, out_bvalid;

  riscv_v_bw_reduct_unit #(.NUM_BYTES(NB), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_reduct(in_reduct), .in_osize(in_osize), .in_last(in_last),
    .srca_data(srca_data), .srcb_data(srcb_data), .srca_bvalid(srca_bvalid),
    .srcb_bvalid(srcb_bvalid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_bvalid(out_bvalid), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op; logic red; logic [1:0] osz; logic last;
    logic [W-1:0] a, b; logic [NB-1:0] av, bv;
  } beat_t;
  typedef struct { logic [W-1:0] d; logic [NB-1:0] bv; logic err; } res_t;
  typedef struct { beat_t i; res_t e; } vec_t;

  int n_chk, n_bad;
  bit mon_en;
  vec_t tbl[10];
  beat_t b;

  // reference model state
  bit            m_grp;
  logic [1:0]    m_op, m_osz;
  logic [W-1:0]  m_b;
  logic [NB-1:0] m_bv;
  logic [W-1:0]  m_a[$];
  logic [NB-1:0] m_av[$];
  res_t          exp_q[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [1:0] op, input logic red, input logic [1:0] osz,
                               input logic last, input logic [W-1:0] a, input logic [W-1:0] bb,
                               input logic [NB-1:0] av, input logic [NB-1:0] bv);
    beat_t r;
    r.op = op; r.red = red; r.osz = osz; r.last = last;
    r.a = a; r.b = bb; r.av = av; r.bv = bv;
    return r;
  endfunction

  function automatic vec_t mkv(input beat_t i, input logic [W-1:0] d, input logic [NB-1:0] bv,
                               input logic err);
    vec_t v;
    v.i = i; v.e.d = d; v.e.bv = bv; v.e.err = err;
    return v;
  endfunction

  function automatic logic [63:0] f_op(input logic [1:0] op, input logic [63:0] x,
                                       input logic [63:0] y);
    if (op == 2'd0) return x & y;
    if (op == 2'd1) return x | y;
    if (op == 2'd2) return x ^ y;
    return 64'd0;
  endfunction

  function automatic res_t ref_ew(input beat_t x);
    res_t r;
    r.bv  = x.av;
    r.err = (x.op == 2'd3);
    r.d   = (x.op == 2'd0) ? (x.a & x.b) : (x.op == 2'd1) ? (x.a | x.b) :
            (x.op == 2'd2) ? (x.a ^ x.b) : '0;
    return r;
  endfunction

  // Combine srcb element 0 and every srca element of every beat, element by element.
  function automatic res_t ref_red(input bit ovf);
    res_t r; int sz, idx; logic [63:0] acc, v; logic [7:0] id;
    logic [W-1:0] la; logic [NB-1:0] lav;
    sz  = 1 << m_osz;
    id  = (m_op == 2'd0) ? 8'hFF : 8'h00;
    acc = {8{id}};
    v   = '0;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = m_bv[k] ? m_b[8*k +: 8] : id;
    acc = f_op(m_op, acc, v);
    for (int j = 0; j < m_a.size(); j++) begin
      la = m_a[j]; lav = m_av[j];
      for (int e = 0; e < NB/sz; e++) begin
        v = '0;
        for (int k = 0; k < sz; k++) begin
          idx = e*sz + k;
          v[8*k +: 8] = lav[idx] ? la[8*idx +: 8] : id;
        end
        acc = f_op(m_op, acc, v);
      end
    end
    r.d = '0; r.bv = '0;
    for (int k = 0; k < sz; k++) begin
      r.d[8*k +: 8] = acc[8*k +: 8];
      r.bv[k] = 1'b1;
    end
    if (m_op == 2'd3) r.d = '0;
    r.err = ovf || (m_op == 2'd3);
    return r;
  endfunction

  task automatic model_beat(input beat_t x);
    if (!m_grp && !x.red) exp_q.push_back(ref_ew(x));
    else begin
      if (!m_grp) begin
        m_grp = 1; m_op = x.op; m_osz = x.osz; m_b = x.b; m_bv = x.bv;
        m_a.delete(); m_av.delete();
      end
      m_a.push_back(x.a); m_av.push_back(x.av);
      if (x.last || m_a.size() == MB) begin
        exp_q.push_back(ref_red(!x.last));
        m_grp = 0;
      end
    end
  endtask

  task automatic drive(input beat_t x);
    in_op = x.op; in_reduct = x.red; in_osize = x.osz; in_last = x.last;
    srca_data = x.a; srcb_data = x.b; srca_bvalid = x.av; srcb_bvalid = x.bv;
  endtask

  task automatic step(input beat_t x);
    drive(x); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input beat_t x);
    int guard; bit acc;
    guard = 0;
    drive(x); in_valid = 1'b1;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      guard++;
    end while (!acc && guard < 100);
    in_valid = 1'b0;
    if (!acc) begin
      n_chk++; n_bad++;
      $display("FAIL send_timeout got=no_accept want=accept");
    end else model_beat(x);
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int k = 0; k < W/32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic beat_t rnd_beat(input bit last);
    beat_t r;
    r.op   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    r.red  = ($urandom_range(0, 3) != 0);
    r.osz  = 2'($urandom_range(0, 3));
    r.last = last;
    r.a    = ($urandom_range(0, 1) != 0) ? rnd_w() : (rnd_w() & rnd_w() & rnd_w());
    r.b    = rnd_w();
    r.av   = ($urandom_range(0, 1) != 0) ? '1 : NB'($urandom);
    r.bv   = ($urandom_range(0, 1) != 0) ? '1 : NB'($urandom);
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_bad++;
        $display("FAIL sb_unexpected got=%h want=none", out_data);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("rnd_data", out_data, e.d);
        chk("rnd_bvalid", W'(out_bvalid), W'(e.bv));
        chk("rnd_err", W'(out_err), W'(e.err));
      end
    end
  end

  initial begin
    n_chk = 0; n_bad = 0; mon_en = 0; m_grp = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(0, 0, 0, 0, '0, '0, '0, '0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_data", out_data, '0);
    chk("rst_bvalid", W'(out_bvalid), '0);
    chk("rst_err", W'(out_err), '0);
    chk("rst_ready", W'(in_ready), W'(1));

    tbl[0] = mkv(mk(1, 0, 0, 0, {NB{8'h0F}}, {NB{8'hF0}}, '1, '1), {NB{8'hFF}}, '1, 0);
    tbl[1] = mkv(mk(0, 0, 0, 0, '1, {NB{8'h55}}, '1, '1), {NB{8'h55}}, '1, 0);
    tbl[2] = mkv(mk(2, 0, 0, 0, {NB{8'hAA}}, '1, 16'h00FF, '1), {NB{8'h55}}, 16'h00FF, 0);
    tbl[3] = mkv(mk(3, 0, 0, 0, {NB{8'h12}}, {NB{8'h34}}, 16'hF0F0, '1), '0, 16'hF0F0, 1);
    tbl[4] = mkv(mk(2, 1, 0, 1, 128'h100F0E0D0C0B0A090807060504030201, '0, '1, '1),
                 W'(8'h10), 16'h0001, 0);
    tbl[5] = mkv(mk(1, 1, 1, 1, 128'h0000_0000_0000_0000_0000_8000_0000_0000, W'(1), '1, '1),
                 W'(16'h8001), 16'h0003, 0);
    tbl[6] = mkv(mk(3, 1, 0, 1, {NB{8'h77}}, {NB{8'h11}}, '1, '1), '0, 16'h0001, 1);
    tbl[7] = mkv(mk(0, 1, 3, 1, {NB{8'h3C}}, 128'hDEADBEEF_00000000_12345678_9ABCDEF0, '0, '1),
                 W'(64'h12345678_9ABCDEF0), 16'h00FF, 0);
    tbl[8] = mkv(mk(2, 1, 2, 1, 128'h88888888_44444444_22222222_11111111, 128'hFFFFFF0F,
                    '1, 16'h0001), W'(32'hFFFFFFF0), 16'h000F, 0);
    tbl[9] = mkv(mk(0, 1, 1, 1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00FFFFFF, '1, 16'hFFF7, '1),
                 W'(16'hFFFF), 16'h0003, 0);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].i);
      chk($sformatf("vec%0d_valid", i), W'(out_valid), W'(1));
      chk($sformatf("vec%0d_data", i), out_data, tbl[i].e.d);
      chk($sformatf("vec%0d_bvalid", i), W'(out_bvalid), W'(tbl[i].e.bv));
      chk($sformatf("vec%0d_err", i), W'(out_err), W'(tbl[i].e.err));
    end

    // 4-beat 32b AND; later beats carry a different op/osize and one element-wise flag
    b = mk(0, 1, 2, 0, '1, '1, '1, '1);
    step(b);
    chk("and4_b1_valid", W'(out_valid), '0);
    b.op = 2; b.osz = 0;
    step(b);
    b.a = 128'hFFFFFFFF_FFFFFFFF_FFFF00FF_FFFFFFFF; b.red = 0;
    step(b);
    chk("and4_b3_valid", W'(out_valid), '0);
    b.a = '1; b.op = 1; b.last = 1;
    step(b);
    chk("and4_valid", W'(out_valid), W'(1));
    chk("and4_data", out_data, W'(32'hFFFF00FF));
    chk("and4_bvalid", W'(out_bvalid), W'(16'h000F));
    chk("and4_err", W'(out_err), '0);

    // backpressure: held result stays put, then drain and accept in one edge
    step(mk(2, 0, 0, 0, {NB{8'hA5}}, '0, '1, '1));
    out_ready = 1'b0;
    drive(mk(1, 0, 0, 0, {NB{8'h3C}}, '0, '1, '1)); in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_ready", W'(in_ready), '0);
      chk("bp_hold", out_data, {NB{8'hA5}});
    end
    out_ready = 1'b1; #1;
    chk("bp_ready_rel", W'(in_ready), W'(1));
    @(posedge clk); #1; in_valid = 1'b0;
    chk("bp_valid", W'(out_valid), W'(1));
    chk("bp_next", out_data, {NB{8'h3C}});

    // overflow after MAX_BEATS beats without in_last
    for (int j = 0; j < MB; j++) begin
      step(mk(1, 1, 0, 0, W'(1) << j, '0, '1, '1));
      if (j == MB-2) chk("ovf_early_valid", W'(out_valid), '0);
    end
    chk("ovf_valid", W'(out_valid), W'(1));
    chk("ovf_err", W'(out_err), W'(1));
    chk("ovf_data", out_data, W'(8'hFF));
    chk("ovf_bvalid", W'(out_bvalid), W'(16'h0001));
    step(mk(0, 0, 0, 0, '1, {NB{8'h0F}}, '1, '1));
    chk("ovf_idle_ew", out_data, {NB{8'h0F}});
    chk("ovf_idle_err", W'(out_err), '0);

    // reset mid-group discards the partial accumulation
    b = mk(1, 1, 0, 0, '1, '0, '1, '1);
    step(b); step(b);
    chk("rmid_valid", W'(out_valid), '0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rmid_rst_valid", W'(out_valid), '0);
    chk("rmid_rst_ready", W'(in_ready), W'(1));
    step(mk(1, 1, 0, 1, W'(1), W'(2), '1, '1));
    chk("rmid_fresh_valid", W'(out_valid), W'(1));
    chk("rmid_fresh_data", out_data, W'(8'h03));
    chk("rmid_fresh_bvalid", W'(out_bvalid), W'(16'h0001));

    // random groups with random consumer stalls
    @(posedge clk); #1;
    mon_en = 1; m_grp = 0;
    for (int g = 0; g < 150; g++) begin
      int len;
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
        send(rnd_beat(j == len-1));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 1) != 0);
        end
      end
    end
    send(mk(1, 1, 0, 1, rnd_w(), rnd_w(), '1, '1));
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("sb_empty", W'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
